// File: rtl/imem_pkg.sv
// Shared defaults and loader state encoding for the instruction memory bank.
// Imported by the loader FSM and the bank top.
package imem_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int DEPTH_DEF     = 16;
    localparam int NUM_SLOTS_DEF = 4;
    localparam int NOP_WORD      = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ZFILL,
        DONE
    } load_state_e;

endpackage

// File: rtl/imem_load_fsm.sv
// Program loader: accepts words into one slot, zero-fills the tail,
// then pulses done and marks the slot loaded.
module imem_load_fsm
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SLOT_W = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              wr_en,
    output logic              wr_zero,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [SLOT_W-1:0] cur_slot,
    output logic              clr_loaded,
    output logic              set_loaded
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    load_state_e       state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [SLOT_W-1:0] slot, slot_n;

    // State, write pointer and captured slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            slot  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            slot  <= slot_n;
        end
    end

    // Next-state and loader outputs
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        slot_n     = slot;
        load_ready = 1'b0;
        load_busy  = 1'b1;
        load_done  = 1'b0;
        wr_en      = 1'b0;
        wr_zero    = 1'b0;
        clr_loaded = 1'b0;
        set_loaded = 1'b0;
        unique case (state)
            IDLE: begin
                load_busy = 1'b0;
                if (load_start) begin
                    slot_n     = load_slot;
                    ptr_n      = '0;
                    clr_loaded = 1'b1;
                    state_n    = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    wr_en = 1'b1;
                    if (ptr == LAST) begin
                        state_n = DONE;
                    end else begin
                        ptr_n = ptr + 1'b1;
                        if (load_last) state_n = ZFILL;
                    end
                end
            end
            ZFILL: begin
                wr_en   = 1'b1;
                wr_zero = 1'b1;
                if (ptr == LAST) state_n = DONE;
                else ptr_n = ptr + 1'b1;
            end
            DONE: begin
                load_done  = 1'b1;
                set_loaded = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign wr_addr  = ptr;
    assign cur_slot = slot;

endmodule

// File: rtl/imem_bank.sv
// Multi-slot instruction memory: loader writes one slot while the
// fetch port reads the active slot; unloaded slots read as NOP.
module imem_bank
    import imem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic              sel_valid,
    input  logic [SLOT_W-1:0] sel_slot,
    output logic [SLOT_W-1:0] active_slot,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data
);

    localparam int ROWS = 1 << SLOT_W;

    logic [DATA_W-1:0] mem [ROWS*DEPTH];
    logic [ROWS-1:0]   slot_loaded;

    logic              wr_en;
    logic              wr_zero;
    logic [ADDR_W-1:0] wr_addr;
    logic [SLOT_W-1:0] cur_slot;
    logic              clr_loaded;
    logic              set_loaded;
    logic              fetch_acc;

    imem_load_fsm #(
        .DEPTH  (DEPTH),
        .SLOT_W (SLOT_W)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_slot  (load_slot),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .wr_en      (wr_en),
        .wr_zero    (wr_zero),
        .wr_addr    (wr_addr),
        .cur_slot   (cur_slot),
        .clr_loaded (clr_loaded),
        .set_loaded (set_loaded)
    );

    // Stall only when the slot being rewritten is the one we fetch from
    assign fetch_ready = !(load_busy && (cur_slot == active_slot));
    assign fetch_acc   = fetch_valid && fetch_ready;

    // Storage write port; contents survive reset, masked by slot_loaded
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{cur_slot, wr_addr}] <= wr_zero ? DATA_W'(NOP_WORD) : load_data;
        end
    end

    // Per-slot loaded flags: cleared at load start, set on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_loaded <= '0;
        end else if (clr_loaded) begin
            slot_loaded[load_slot] <= 1'b0;
        end else if (set_loaded) begin
            slot_loaded[cur_slot] <= 1'b1;
        end
    end

    // Active slot select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_slot <= '0;
        end else if (sel_valid) begin
            active_slot <= sel_slot;
        end
    end

    // Registered fetch response, using the slot active before any select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr_data  <= '0;
        end else begin
            instr_valid <= fetch_acc;
            if (fetch_acc) begin
                instr_data <= slot_loaded[active_slot] ?
                              mem[{active_slot, fetch_addr}] :
                              DATA_W'(NOP_WORD);
            end
        end
    end

endmodule

// File: tb/tb_imem_bank.sv
// Scoreboard bench for imem_bank: directed scenarios plus random
// loads/fetches against an array-based model of the slots.
module tb_imem_bank;

    localparam int DW  = 16;
    localparam int DEP = 16;
    localparam int NS  = 4;
    localparam int AW  = 4;
    localparam int SW  = 2;

    typedef logic [DW-1:0] wq_t[$];
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [SW-1:0] load_slot = '0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic          sel_valid = 1'b0;
    logic [SW-1:0] sel_slot = '0;
    logic [SW-1:0] active_slot;
    logic          fetch_valid = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_ready;
    logic          instr_valid;
    logic [DW-1:0] instr_data;

    imem_bank #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .NUM_SLOTS (NS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_slot   (load_slot),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .sel_valid   (sel_valid),
        .sel_slot    (sel_slot),
        .active_slot (active_slot),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr_data  (instr_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model
    logic [DW-1:0] mdl_mem [NS][DEP];
    bit            mdl_loaded [NS];
    int            mdl_active = 0;
    bit            mdl_busy = 0;
    int            mdl_lslot = 0;
    exp_t          sbq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: every instr_valid must match the oldest expected fetch
    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            if (sbq.size() == 0) begin
                timeout("spurious_instr_valid");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("instr_data", instr_data, e.data);
                chk("instr_latency", cyc, e.cyc);
            end
        end
    end

    task automatic do_fetch(input int addr, input bit do_sel, input int s);
        int  n;
        bit  ok;
        bit  exp_rdy;
        exp_t e;
        n  = 0;
        ok = 0;
        fetch_valid = 1'b1;
        fetch_addr  = AW'(addr);
        while (n < 200) begin
            @(negedge clk);
            exp_rdy = !(mdl_busy && mdl_lslot == mdl_active);
            chk("fetch_ready", fetch_ready, exp_rdy);
            if (fetch_ready) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) begin
            timeout("fetch_wait");
            fetch_valid = 1'b0;
            return;
        end
        e.data = mdl_loaded[mdl_active] ? mdl_mem[mdl_active][addr] : '0;
        e.cyc  = cyc + 1;
        sbq.push_back(e);
        if (do_sel) begin
            sel_valid = 1'b1;
            sel_slot  = SW'(s);
        end
        @(posedge clk);
        if (do_sel) mdl_active = s;
        #1;
        fetch_valid = 1'b0;
        sel_valid   = 1'b0;
    endtask

    task automatic load_prog(input int slot, input wq_t words,
                             input bit use_last, input bit extra,
                             input bit poke);
        int n;
        int nz;
        int w;
        bit ok;
        n = words.size();
        load_start = 1'b1;
        load_slot  = SW'(slot);
        @(posedge clk);
        mdl_busy = 1;
        mdl_lslot = slot;
        mdl_loaded[slot] = 0;
        #1;
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = use_last && (i == n - 1);
            if (poke && i == 1) begin
                load_start = 1'b1;
                load_slot  = SW'(slot ^ 1);
            end
            ok = 0;
            w  = 0;
            while (w < 50) begin
                @(negedge clk);
                if (load_ready) begin
                    ok = 1;
                    break;
                end
                w++;
            end
            if (!ok) timeout("load_ready_wait");
            @(posedge clk);
            #1;
            load_start = 1'b0;
        end
        load_valid = extra;
        load_last  = 1'b0;
        load_data  = DW'($urandom);
        nz = 0;
        ok = 0;
        while (nz < 60) begin
            @(negedge clk);
            chk("load_ready_after_last", load_ready, 1'b0);
            if (load_done) begin
                ok = 1;
                break;
            end
            nz++;
        end
        if (!ok) timeout("load_done_wait");
        chk("zfill_cycles", nz, (n < DEP) ? DEP - n : 0);
        @(posedge clk);
        mdl_busy = 0;
        for (int j = 0; j < DEP; j++)
            mdl_mem[slot][j] = (j < n) ? words[j] : '0;
        mdl_loaded[slot] = 1;
        #1;
        load_valid = 1'b0;
        @(negedge clk);
        chk("load_done_pulse", load_done, 1'b0);
        chk("load_busy_idle", load_busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_stream(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            do_fetch($urandom_range(DEP - 1), ($urandom_range(3) == 0),
                     $urandom_range(NS - 1));
            if ($urandom_range(1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wq_t p;
        for (int s = 0; s < NS; s++) mdl_loaded[s] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_load_busy", load_busy, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_active_slot", active_slot, 0);
        chk("rst_fetch_ready", fetch_ready, 1'b1);
        @(posedge clk);
        #1;

        // Short program with zero fill
        p = {16'h0000, 16'h1400, 16'h1304, 16'h3C02, 16'hF000};
        load_prog(0, p, 1, 0, 0);
        do_fetch(3, 0, 0);
        do_fetch(7, 0, 0);

        // Full slot without last, then an extra word offered
        p = {};
        for (int i = 0; i < DEP; i++) p.push_back(DW'($urandom));
        load_prog(2, p, 0, 1, 0);
        do_fetch(15, 1, 2);
        do_fetch(15, 0, 0);

        // Same-cycle select uses old slot (slot 1 unloaded)
        do_fetch(0, 1, 1);
        do_fetch(1, 1, 0);
        do_fetch(1, 0, 0);

        // Fetch stalls while the active slot is being loaded
        do_fetch(0, 1, 1);
        p = {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
        fork
            load_prog(1, p, 1, 0, 0);
            begin
                @(posedge clk);
                #1;
                do_fetch(2, 0, 0);
            end
        join

        // Fetch from the active slot while another slot loads
        p = {16'hB001, 16'hB002, 16'hB003};
        fork
            load_prog(3, p, 1, 0, 0);
            begin
                @(posedge clk);
                #1;
                do_fetch(4, 0, 0);
                do_fetch(5, 0, 0);
            end
        join

        // load_start during LOAD is ignored
        p = {16'hC001, 16'hC002, 16'hC003, 16'hC004,
             16'hC005, 16'hC006, 16'hC007, 16'hC008};
        load_prog(1, p, 1, 0, 1);
        do_fetch(4, 0, 0);
        do_fetch(1, 1, 0);
        do_fetch(1, 0, 0);

        // Random loads with concurrent fetches and selects
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(DEP, 1);
            p = {};
            for (int i = 0; i < n; i++) p.push_back(DW'($urandom));
            fork
                load_prog($urandom_range(NS - 1), p,
                          (n < DEP) ? 1'b1 : 1'($urandom_range(1)), 0, 0);
                fetch_stream(12);
            join
        end

        // Reset in the middle of zero fill on slot 0
        do_fetch(2, 1, 3);
        repeat (2) @(posedge clk);
        #1;
        load_start = 1'b1;
        load_slot  = '0;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 16'h1234;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("zfill_busy", load_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < NS; s++) mdl_loaded[s] = 0;
        mdl_active = 0;
        mdl_busy   = 0;
        chk("arst_load_busy", load_busy, 1'b0);
        chk("arst_load_ready", load_ready, 1'b0);
        chk("arst_load_done", load_done, 1'b0);
        chk("arst_instr_valid", instr_valid, 1'b0);
        chk("arst_instr_data", instr_data, 0);
        chk("arst_active_slot", active_slot, 0);
        chk("arst_fetch_ready", fetch_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_fetch(1, 0, 0);
        do_fetch(0, 0, 0);

        // Reload after reset
        p = {16'hD00D, 16'hBEEF};
        load_prog(0, p, 1, 0, 0);
        do_fetch(1, 0, 0);
        do_fetch(9, 0, 0);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_bank.md
IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, words per slot; power of two, at least 2.
REQ-003 SHALL have parameter NUM_SLOTS, default 4, independent program slots; power of two, at least 1.
REQ-004 SHALL have derived ADDR_W = clog2(DEPTH) and SLOT_W = max(1, clog2(NUM_SLOTS)).
REQ-005 SHALL have these ports, as name, direction, width, meaning:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- load_start, in, 1: begin loading slot load_slot.
- load_slot, in, SLOT_W: target slot, sampled with load_start.
- load_valid, in, 1: load_data is valid.
- load_data, in, DATA_W: program word.
- load_last, in, 1: marks the final word of the program.
- load_ready, out, 1: loader accepts a word this cycle.
- load_busy, out, 1: load in progress.
- load_done, out, 1: one-cycle completion pulse.
- sel_valid, in, 1: request to change the active slot.
- sel_slot, in, SLOT_W: new active slot.
- active_slot, out, SLOT_W: slot currently fetched from.
- fetch_valid, in, 1: fetch request.
- fetch_addr, in, ADDR_W: word address.
- fetch_ready, out, 1: fetch accepted this cycle.
- instr_valid, out, 1: instr_data is valid.
- instr_data, out, DATA_W: fetched instruction.

Function
REQ-006 SHALL store NUM_SLOTS x DEPTH words of DATA_W bits, with one slot_loaded flag per slot.
REQ-007 Loader FSM SHALL have states IDLE, LOAD, ZFILL and DONE.
REQ-008 In IDLE, load_start SHALL capture load_slot, clear slot_loaded for that slot, reset the write pointer to 0 and go to LOAD next cycle.
REQ-009 In LOAD, load_ready SHALL be 1; each load_valid&&load_ready cycle SHALL write load_data at the pointer and then increment it.
REQ-010 An accepted word with load_last=1 at pointer less than DEPTH-1 SHALL move the FSM to ZFILL.
REQ-011 ZFILL SHALL write 0 (NOP) to each remaining address, one per cycle, through DEPTH-1, then go to DONE.
REQ-012 An accepted word at pointer DEPTH-1, whether or not load_last is set, SHALL go directly to DONE; any further words are not accepted.
REQ-013 DONE SHALL pulse load_done for one cycle, set slot_loaded for the slot and return to IDLE.
REQ-014 load_busy SHALL be 1 in LOAD, ZFILL and DONE; load_start SHALL be ignored while busy; load_ready SHALL be 0 outside LOAD.
REQ-015 fetch_ready SHALL be 0 while load_busy=1 and the captured slot equals active_slot; otherwise it SHALL be 1.
REQ-016 An accepted fetch SHALL give instr_valid=1 on the next cycle; instr_valid SHALL be 0 in all other cycles.
REQ-017 The fetched word SHALL be mem[active_slot][fetch_addr], or 0 if slot_loaded[active_slot]=0.
REQ-018 sel_valid SHALL update active_slot on the next edge.
REQ-019 A fetch in the same cycle as sel_valid SHALL use the old active_slot.
REQ-020 Selecting a slot that is currently loading SHALL be legal; fetch then stalls per REQ-015.
REQ-021 Fetches from a non-active slot being loaded SHALL proceed unaffected.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: FSM to IDLE, pointer 0, all slot_loaded 0, active_slot 0, load_done 0, instr_valid 0, instr_data 0.
REQ-023 Storage contents SHALL NOT be reset; REQ-017 masks unloaded slots.
REQ-024 Reset during a load SHALL abandon it; that slot reads 0 until it is fully reloaded.

Structure
REQ-025 Package imem_pkg SHALL hold the default DATA_W, DEPTH and NUM_SLOTS, NOP_WORD = 0, and the loader state enum.
REQ-026 The loader FSM and pointer SHALL be sub-module imem_load_fsm; storage and the fetch path stay in imem_bank.

Verification
REQ-027 Load slot 0 with 0x0000, 0x1400, 0x1304, 0x3C02, 0xF000 (last on the 5th word). Required: 11 ZFILL cycles, then load_done; fetch addr 3 returns 0x3C02 one cycle later; addr 7 returns 0x0000.
REQ-028 Load 16 words into slot 2 without load_last. Required: DONE after the 16th word; a 17th load_valid is not accepted.
REQ-029 Active slot 1 with a load of slot 1 in progress, fetch_valid=1. Required: fetch_ready=0 until the load_done cycle passes, then the fetch proceeds.
REQ-030 Fetch addr 1 with sel_valid=1, sel_slot=0 in the same cycle while active_slot=1 and slot 1 unloaded. Required: returns 0x0000; the next fetch reads slot 0 (0x1400).
REQ-031 Assert rst_n=0 mid-ZFILL on slot 0. Required: outputs go to reset values immediately; fetch of slot 0 addr 1 returns 0x0000.
REQ-032 Assert load_start during LOAD. Required: ignored; the load continues to its original slot.
